data_mem_ctrl: RTL and testbench

- Byte-addressed, parametrised RV32 data memory with a valid/ready request port and a fixed-latency response.
- Supports RISC-V load/store sizes (B/H/W), sign/zero extension, byte-lane writes, and error reporting for misaligned, out-of-range and illegal accesses.
- Sits between the core's LSU/MEM stage and the on-chip data RAM.
- Generalises the earlier word-only, negedge, read-priority data memory.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/data_mem_ctrl_if.sv | 38 +++
 rtl/dmem_load_align.sv | 47 ++++
 rtl/data_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the RV32 data memory controller.
//   - RISC-V load/store funct3 size encodings (SZ_B .. SZ_HU)
//   - controller FSM state type
//   - byte_enables(): 4-bit lane mask for a store of a given size/offset
// ---------------------------------------------------------------------------
package dmem_pkg;

  // funct3 encodings for loads/stores
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Lane mask for a 32-bit word. Offset is assumed to be already aligned for
  // halves and words; halves pick the upper or lower pair using offset[1].
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B, SZ_BU: be = 4'b0001 << offset;
      SZ_H, SZ_HU: be = offset[1] ? 4'b1100 : 4'b0011;
      SZ_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between a load/store unit and data_mem_ctrl.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_we              : 1 = store, 0 = load
//   req_size            : RISC-V funct3 size
//   req_addr            : byte address
//   req_wdata           : store data, right-aligned
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : access faulted, no state change
// Modports: master = requester side, slave = memory controller side.
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_size;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_load_align.sv
// ---------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter: picks the addressed byte or half out of a
// 32-bit RAM word, shifts it down to bit 0 and sign- or zero-extends it.
//   word   in  XLEN  raw RAM word
//   offset in  2     byte offset within the word (already aligned for H/W)
//   size   in  3     funct3 size of the load
//   data   out XLEN  formatted load result (0 for unsupported sizes)
// ---------------------------------------------------------------------------
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      size,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    half_sel = offset[1] ? word[31:16] : word[15:0];

    data = '0;
    case (size)
      SZ_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      SZ_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      SZ_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      SZ_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      SZ_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressed RV32 data memory with a valid/ready request port and a
// fixed-latency response pulse. Handles B/H/W stores with byte lanes,
// signed/unsigned B/H loads, and flags illegal, out-of-range and (optionally)
// misaligned accesses. Only XLEN = 32 is supported.
//
// Parameters:
//   XLEN    data/address width (32)
//   DEPTH   number of 32-bit words, power of two, >= 2
//   LATENCY cycles from acceptance to resp_valid, >= 1
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (RAM contents are kept)
//   bus    data_mem_ctrl_if.slave request/response bundle
//
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses return resp_err
//   undefined : misaligned H/HU/W addresses are force-aligned downward
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  data_mem_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  // WAIT ends when the counter has seen LATENCY-2 increments beyond entry,
  // i.e. LATENCY-1 cycles after the acceptance edge.
  localparam logic [CW-1:0] CNT_LAST = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q,   err_d;

  logic            req_ready;
  logic            mem_we;
  logic            illegal;
  logic            out_of_range;
  logic            acc_err;
  logic [1:0]      eff_off;
  logic [AW-1:0]   word_idx;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] load_data;

  // Access decode: error classification, effective byte offset and the RAM
  // word addressed. All three error kinds collapse onto a single flag.
  always_comb begin
    if (bus.req_we) begin
      illegal = (bus.req_size >= 3'b011);
    end else begin
      illegal = (bus.req_size == 3'b011) || (bus.req_size == 3'b110) ||
                (bus.req_size == 3'b111);
    end

    out_of_range = |bus.req_addr[XLEN-1:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    eff_off = bus.req_addr[1:0];
    acc_err = illegal || out_of_range ||
              (((bus.req_size == SZ_H) || (bus.req_size == SZ_HU)) && bus.req_addr[0]) ||
              ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
    // Misaligned addresses are rounded down to the natural boundary.
    eff_off = bus.req_addr[1:0];
    if ((bus.req_size == SZ_H) || (bus.req_size == SZ_HU)) begin
      eff_off = {bus.req_addr[1], 1'b0};
    end else if (bus.req_size == SZ_W) begin
      eff_off = 2'b00;
    end
    acc_err = illegal || out_of_range;
`endif

    word_idx = bus.req_addr[AW+1:2];
  end

  // Store data is replicated across lanes so the byte enables alone decide
  // which bytes land in the word.
  always_comb begin
    lane_be = byte_enables(bus.req_size, eff_off);
    case (bus.req_size)
      SZ_B, SZ_BU: lane_data = {4{bus.req_wdata[7:0]}};
      SZ_H, SZ_HU: lane_data = {2{bus.req_wdata[15:0]}};
      default:     lane_data = bus.req_wdata;
    endcase
  end

  assign rd_word = mem[word_idx];

  dmem_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .word   (rd_word),
    .offset (eff_off),
    .size   (bus.req_size),
    .data   (load_data)
  );

  // FSM next-state and response capture. A request is taken only in IDLE;
  // the load result or error flag is latched at that edge and held until
  // the response pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          err_d   = acc_err;
          rdata_d = (!bus.req_we && !acc_err) ? load_data : '0;
          mem_we  = bus.req_we && !acc_err && !reset;
          cnt_d   = '0;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers. Reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM array: stores commit on the acceptance edge, lane by lane, and the
  // contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl. Two instances share clock, reset and
// request fields: dut1 with LATENCY=1 and dut3 with LATENCY=3; use3 picks
// which one sees req_valid and whose outputs are observed.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  bit          use3;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.XLEN(32)) bus1 ();
  data_mem_ctrl_if #(.XLEN(32)) bus3 ();

  assign bus1.req_valid = req_valid & ~use3;
  assign bus3.req_valid = req_valid &  use3;
  assign bus1.req_we    = req_we;
  assign bus3.req_we    = req_we;
  assign bus1.req_size  = req_size;
  assign bus3.req_size  = req_size;
  assign bus1.req_addr  = req_addr;
  assign bus3.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus3.req_wdata = req_wdata;

  wire        m_ready      = use3 ? bus3.req_ready  : bus1.req_ready;
  wire        m_resp_valid = use3 ? bus3.resp_valid : bus1.resp_valid;
  wire [31:0] m_rdata      = use3 ? bus3.resp_rdata : bus1.resp_rdata;
  wire        m_err        = use3 ? bus3.resp_err   : bus1.resp_err;

  data_mem_ctrl #(.XLEN(32), .DEPTH(512), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  data_mem_ctrl #(.XLEN(32), .DEPTH(512), .LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for acceptance and then for the response pulse.
  // lat counts negedges from the acceptance edge to the first resp_valid.
  task automatic applyStimulus(input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    int waits;
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    while (!m_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!m_ready) begin
      checkOutput("accept_timeout", 32'(m_ready), 32'd1);
      req_valid = 1'b0;
      rdata = '0;
      err   = 1'b1;
      lat   = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = m_rdata;
    err   = m_err;
  endtask

  task automatic runOp(input string tag, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    applyStimulus(we, size, addr, wdata, rdata, err, lat);
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] rdy_seen;
    logic [11:0] rv_seen;
    int          rv_count;

    vectors     = 0;
    miscompares = 0;
    use3        = 1'b0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_size    = 3'b010;
    req_addr    = '0;
    req_wdata   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready1", 32'(bus1.req_ready), 32'd1);
    checkOutput("rst_rvalid1", 32'(bus1.resp_valid), 32'd0);
    checkOutput("rst_rdata1", bus1.resp_rdata, 32'd0);
    checkOutput("rst_err1", 32'(bus1.resp_err), 32'd0);
    checkOutput("rst_ready3", 32'(bus3.req_ready), 32'd1);

    $display("[TB] LATENCY=1 functional vectors");
    runOp("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    runOp("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1);
    runOp("sb11",  1'b1, 3'b000, 32'h11, 32'h00000080, 32'h0,        1'b0, 1);
    runOp("lw10b", 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0, 1);
    runOp("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 1);
    runOp("lbu11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0, 1);
    runOp("sh12",  1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0, 1);
    runOp("lh12",  1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0, 1);
    runOp("lhu10", 1'b0, 3'b101, 32'h10, 32'h0,        32'h000080EF, 1'b0, 1);
    runOp("lh10",  1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFF80EF, 1'b0, 1);
    runOp("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'h00000012, 1'b0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    runOp("lw13",  1'b0, 3'b010, 32'h13, 32'h0,        32'h0,        1'b1, 1);
    runOp("lh11",  1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 1);
`else
    runOp("lw13",  1'b0, 3'b010, 32'h13, 32'h0,        32'h123480EF, 1'b0, 1);
    runOp("lh11",  1'b0, 3'b001, 32'h11, 32'h0,        32'hFFFF80EF, 1'b0, 1);
`endif
    runOp("sw00",  1'b1, 3'b010, 32'h0,   32'h11223344, 32'h0,        1'b0, 1);
    runOp("swoor", 1'b1, 3'b010, 32'h800, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    runOp("lw00",  1'b0, 3'b010, 32'h0,   32'h0,        32'h11223344, 1'b0, 1);
    runOp("lwhi",  1'b0, 3'b010, 32'h80000000, 32'h0,   32'h0,        1'b1, 1);
    runOp("ldsz3", 1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1);
    runOp("ldsz6", 1'b0, 3'b110, 32'h10,  32'h0,        32'h0,        1'b1, 1);
    runOp("stsz4", 1'b1, 3'b100, 32'h10,  32'h0,        32'h0,        1'b1, 1);
    runOp("lw10c", 1'b0, 3'b010, 32'h10,  32'h0,        32'h123480EF, 1'b0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    runOp("sw12",  1'b1, 3'b010, 32'h12,  32'hCAFEF00D, 32'h0,        1'b1, 1);
    runOp("lw10d", 1'b0, 3'b010, 32'h10,  32'h0,        32'h123480EF, 1'b0, 1);
`else
    runOp("sw12",  1'b1, 3'b010, 32'h12,  32'hCAFEF00D, 32'h0,        1'b0, 1);
    runOp("lw10d", 1'b0, 3'b010, 32'h10,  32'h0,        32'hCAFEF00D, 1'b0, 1);
`endif

    $display("[TB] LATENCY=3 handshake with req_valid held high");
    use3 = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h40;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rdy_seen[i] = m_ready;
      rv_seen[i]  = m_resp_valid;
    end
    req_valid = 1'b0;
    checkOutput("hs_ready_pattern", 32'(rdy_seen), 32'h111);
    checkOutput("hs_rvalid_pattern", 32'(rv_seen), 32'h888);

    $display("[TB] LATENCY=3 reset during WAIT");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 3'b010;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mid_wait_ready", 32'(m_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_rvalid", 32'(m_resp_valid), 32'd0);
    reset = 1'b0;
    rv_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_resp_valid) rv_count++;
    end
    checkOutput("post_rst_no_resp", 32'(rv_count), 32'd0);
    runOp("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0, 3);
    runOp("stsz3", 1'b1, 3'b011, 32'h20, 32'h00000000, 32'h0,        1'b1, 3);
    runOp("lw20b", 1'b0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
